// File: rtl/alu_issue_unit_if.sv
// Instruction handshake between fetch (master) and the ALU issue unit (slave).
interface alu_issue_unit_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] INSTR;
  logic              INSTR_VALID;
  logic              INSTR_READY;

  modport master (output INSTR, output INSTR_VALID, input INSTR_READY);
  modport slave  (input INSTR, input INSTR_VALID, output INSTR_READY);
endinterface

// File: rtl/alu_issue_unit.sv
// Four-phase issue/writeback controller feeding a single-cycle ALU from a 32x32 regfile.
// Optional retire counter enabled by defining ALU_ISSUE_RETIRE_CNT_EN.
module alu_issue_unit #(
  parameter int DATA_W = 32,
  parameter int NREG_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  alu_issue_unit_if.slave   instr_if,
  output logic [5:0]        OPCODE,
  output logic [DATA_W-1:0] RS_VAL,
  output logic [DATA_W-1:0] RT_VAL,
  output logic [4:0]        SHAMT,
  output logic [5:0]        FUNC,
  output logic [15:0]       RAW_VAL,
  input  logic [DATA_W-1:0] RESULT,
  input  logic              SIG_B,
  output logic              DONE,
  output logic              BR_TAKEN,
  output logic              WB_EN,
  output logic [NREG_W-1:0] WB_ADDR,
  output logic [DATA_W-1:0] WB_DATA,
  input  logic [NREG_W-1:0] DBG_ADDR,
  output logic [DATA_W-1:0] DBG_DATA,
  output logic [15:0]       RETIRED_CNT
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  logic [1:0]        state;
  logic              ready_q;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] regs [2**NREG_W];

  logic [5:0]        dec_op;
  logic [NREG_W-1:0] dec_rs;
  logic [NREG_W-1:0] dec_rt;
  logic [NREG_W-1:0] dec_dest;
  logic              dec_wr;
  logic              dec_branch;

  assign dec_op = instr_q[31:26];
  assign dec_rs = instr_q[25:21];
  assign dec_rt = instr_q[20:16];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_dest   = '0;
    dec_wr     = 1'b0;
    dec_branch = 1'b0;
    unique case (dec_op)
      OP_RTYPE: begin
        dec_dest = instr_q[15:11];
        dec_wr   = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        dec_dest = dec_rt;
        dec_wr   = 1'b1;
      end
      OP_BEQ, OP_BNE: dec_branch = 1'b1;
      default: ;
    endcase
    // r0 is hardwired: a write aimed at it retires as a no-write with address 0.
    if (dec_dest == '0) begin
      dec_wr   = 1'b0;
      dec_dest = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      ready_q  <= 1'b0;
      instr_q  <= '0;
      OPCODE   <= '0;
      RS_VAL   <= '0;
      RT_VAL   <= '0;
      SHAMT    <= '0;
      FUNC     <= '0;
      RAW_VAL  <= '0;
      DONE     <= 1'b0;
      BR_TAKEN <= 1'b0;
      WB_EN    <= 1'b0;
      WB_ADDR  <= '0;
      WB_DATA  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ready_q && instr_if.INSTR_VALID) begin
            instr_q <= instr_if.INSTR;
            ready_q <= 1'b0;
            state   <= S_DECODE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_DECODE: begin
          OPCODE  <= dec_op;
          RS_VAL  <= (dec_rs == '0) ? '0 : regs[dec_rs];
          RT_VAL  <= (dec_rt == '0) ? '0 : regs[dec_rt];
          SHAMT   <= instr_q[10:6];
          FUNC    <= instr_q[5:0];
          RAW_VAL <= instr_q[15:0];
          state   <= S_EXEC;
        end
        S_EXEC: begin
          // WB_DATA doubles as the result register consumed by the regfile write.
          WB_DATA <= RESULT;
          WB_EN   <= dec_wr;
          WB_ADDR <= dec_dest;
          DONE    <= 1'b1;
          if (dec_branch) BR_TAKEN <= SIG_B;
          state   <= S_WB;
        end
        S_WB: begin
          DONE    <= 1'b0;
          WB_EN   <= 1'b0;
          WB_ADDR <= '0;
          WB_DATA <= '0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // NOTE: the regfile is a reset memory here because a reset must leave every register reading 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 2**NREG_W; i++) regs[i] <= '0;
    end else if (state == S_WB && WB_EN) begin
      regs[WB_ADDR] <= WB_DATA;
    end
  end

  assign instr_if.INSTR_READY = ready_q;
  assign DBG_DATA = (DBG_ADDR == '0) ? '0 : regs[DBG_ADDR];

`ifdef ALU_ISSUE_RETIRE_CNT_EN
  logic [15:0] retired_q;

  always_ff @(posedge CLK) begin
    if (RST)       retired_q <= '0;
    else if (DONE) retired_q <= retired_q + 16'd1;
  end

  assign RETIRED_CNT = retired_q;
`else
  assign RETIRED_CNT = '0;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: directed program plus randomized instructions
// against an architectural register-file model; includes a behavioural ALU.
module tb_alu_issue_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_unit_if #(.DATA_W(32)) ifc ();

  logic [5:0]  opcode, func;
  logic [31:0] rs_val, rt_val, result, wb_data, dbg_data;
  logic [4:0]  shamt, wb_addr, dbg_addr;
  logic [15:0] raw_val, retired_cnt;
  logic        sig_b, done, br_taken, wb_en;

  alu_issue_unit dut (
    .CLK(clk), .RST(rst), .instr_if(ifc),
    .OPCODE(opcode), .RS_VAL(rs_val), .RT_VAL(rt_val), .SHAMT(shamt), .FUNC(func),
    .RAW_VAL(raw_val), .RESULT(result), .SIG_B(sig_b), .DONE(done), .BR_TAKEN(br_taken),
    .WB_EN(wb_en), .WB_ADDR(wb_addr), .WB_DATA(wb_data), .DBG_ADDR(dbg_addr),
    .DBG_DATA(dbg_data), .RETIRED_CNT(retired_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;

  logic [31:0] model_rf [32];
  logic        model_br;
  logic [15:0] model_cnt;

  always @(posedge clk) cyc++;

  // Behavioural ALU: returns {branch condition, result}.
  function automatic logic [32:0] alu_ref(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [4:0] sh, input logic [31:0] a,
                                          input logic [31:0] b, input logic [15:0] imm);
    logic [31:0] simm;
    logic [31:0] zimm;
    simm = {{16{imm[15]}}, imm};
    zimm = {16'h0, imm};
    case (op)
      6'b000000: case (fn)
        6'b100000: return {1'b0, a + b};
        6'b100010: return {1'b0, a - b};
        6'b100100: return {1'b0, a & b};
        6'b100101: return {1'b0, a | b};
        6'b101010: return {1'b0, 31'h0, ($signed(a) < $signed(b))};
        6'b000000: return {1'b0, b << sh};
        default:   return {1'b0, a ^ b};
      endcase
      6'b001000: return {1'b0, a + simm};
      6'b001010: return {1'b0, 31'h0, ($signed(a) < $signed(simm))};
      6'b001100: return {1'b0, a & zimm};
      6'b001101: return {1'b0, a | zimm};
      6'b000100: return {(a == b), 32'h0};
      6'b000101: return {(a != b), 32'h0};
      default:   return {1'b0, a + b};
    endcase
  endfunction

  assign {sig_b, result} = alu_ref(opcode, func, shamt, rs_val, rt_val, raw_val);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    return model_cnt;
`else
    return 16'h0;
`endif
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    model_br  = 1'b0;
    model_cnt = 16'h0;
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  task automatic wait_ready(output bit ok);
    int guard = 0;
    while (!ifc.INSTR_READY && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ok = ifc.INSTR_READY;
    if (!ok) check("ready_timeout", {31'h0, ifc.INSTR_READY}, 32'h1);
  endtask

  // Issue one instruction (called at a negedge) and check every phase of it.
  task automatic run_instr(input logic [31:0] ins, input bit check_tp);
    logic [5:0]  op;
    logic [4:0]  rs, rt, dest;
    logic        wr;
    logic [31:0] a, b, res, old;
    logic        sb;
    bit          ok;
    op = ins[31:26];
    rs = ins[25:21];
    rt = ins[20:16];
    wr = 1'b0;
    dest = 5'd0;
    if (op == 6'b000000) begin
      wr = 1'b1; dest = ins[15:11];
    end else if (op == 6'b001000 || op == 6'b001010 || op == 6'b001100 || op == 6'b001101) begin
      wr = 1'b1; dest = rt;
    end
    if (dest == 5'd0) wr = 1'b0;
    if (!wr) dest = 5'd0;
    a = model_rf[rs];
    b = model_rf[rt];
    {sb, res} = alu_ref(op, ins[5:0], ins[10:6], a, b, ins[15:0]);

    wait_ready(ok);
    if (!ok) return;
    dbg_addr = wr ? dest : rt;
    old = model_rf[dbg_addr];
    ifc.INSTR = ins;
    ifc.INSTR_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (check_tp) check("throughput", cyc - last_acc, 4);
    last_acc = cyc;
    check("busy_ready", {31'h0, ifc.INSTR_READY}, 32'h0);
    check("done_early1", {31'h0, done}, 32'h0);
    ifc.INSTR_VALID = 1'($urandom_range(0, 1));
    ifc.INSTR = $urandom;
    @(negedge clk);
    check("opcode", {26'h0, opcode}, {26'h0, op});
    check("rs_val", rs_val, a);
    check("rt_val", rt_val, b);
    check("raw_val", {16'h0, raw_val}, {16'h0, ins[15:0]});
    check("shamt_func", {21'h0, shamt, func}, {21'h0, ins[10:0]});
    check("done_early2", {31'h0, done}, 32'h0);
    ifc.INSTR_VALID = 1'($urandom_range(0, 1));
    ifc.INSTR = $urandom;
    @(negedge clk);
    check("done", {31'h0, done}, 32'h1);
    check("wb_en", {31'h0, wb_en}, {31'h0, wr});
    check("wb_addr", {27'h0, wb_addr}, {27'h0, dest});
    if (wr) check("wb_data", wb_data, res);
    check("dbg_old", dbg_data, old);
    ifc.INSTR_VALID = 1'($urandom_range(0, 1));
    ifc.INSTR = $urandom;
    if (wr) model_rf[dest] = res;
    if (op == 6'b000100 || op == 6'b000101) model_br = sb;
    model_cnt = model_cnt + 16'd1;
    @(negedge clk);
    ifc.INSTR_VALID = 1'b0;
    check("done_pulse", {31'h0, done}, 32'h0);
    check("ready_after", {31'h0, ifc.INSTR_READY}, 32'h1);
    check("br_taken", {31'h0, br_taken}, {31'h0, model_br});
    check("dbg_new", dbg_data, model_rf[dbg_addr]);
    check("retired_cnt", {16'h0, retired_cnt}, {16'h0, exp_cnt()});
  endtask

  task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] v);
    dbg_addr = r;
    #1;
    check(tag, dbg_data, v);
  endtask

  logic [5:0] op_pool [8];
  logic [5:0] fn_pool [6];

  initial begin
    bit ok;
    op_pool = '{6'b000000, 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b000100, 6'b000101, 6'b100011};
    fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    reset_model();
    rst = 1'b1;
    ifc.INSTR = 32'h0;
    ifc.INSTR_VALID = 1'b0;
    dbg_addr = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, ifc.INSTR_READY}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_opcode", {26'h0, opcode}, 32'h0);
    check("rst_rs_val", rs_val, 32'h0);
    check("rst_br", {31'h0, br_taken}, 32'h0);
    check("rst_wb_en", {31'h0, wb_en}, 32'h0);
    check("rst_dbg", dbg_data, 32'h0);
    check("rst_cnt", {16'h0, retired_cnt}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", {31'h0, ifc.INSTR_READY}, 32'h1);

    // Directed program.
    run_instr(32'h2001000D, 1'b0);
    run_instr(mk_i(6'b001000, 5'd1, 5'd2, 16'd19), 1'b1);
    run_instr(mk_r(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 1'b1);
    run_instr(mk_i(6'b001000, 5'd0, 5'd0, 16'd9), 1'b1);
    run_instr(mk_i(6'b000100, 5'd1, 5'd1, 16'd5), 1'b1);
    check("beq_taken", {31'h0, br_taken}, 32'h1);
    run_instr(mk_i(6'b000101, 5'd1, 5'd1, 16'd5), 1'b1);
    check("bne_not_taken", {31'h0, br_taken}, 32'h0);
    check_reg("r1_is_13", 5'd1, 32'd13);
    check_reg("r2_is_32", 5'd2, 32'd32);
    check_reg("r3_is_45", 5'd3, 32'd45);
    check_reg("r0_is_0", 5'd0, 32'd0);
    run_instr(mk_i(6'b000100, 5'd1, 5'd1, 16'd1), 1'b1);

    // Reset during EXEC of ADDI r4,r0,7.
    @(negedge clk);
    wait_ready(ok);
    dbg_addr = 5'd4;
    ifc.INSTR = mk_i(6'b001000, 5'd0, 5'd4, 16'd7);
    ifc.INSTR_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.INSTR_VALID = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done1", {31'h0, done}, 32'h0);
    @(negedge clk);
    check("abort_done2", {31'h0, done}, 32'h0);
    rst = 1'b0;
    reset_model();
    @(negedge clk);
    check("abort_ready", {31'h0, ifc.INSTR_READY}, 32'h1);
    check("abort_r4", dbg_data, 32'h0);
    check("abort_br", {31'h0, br_taken}, 32'h0);
    check("abort_cnt", {16'h0, retired_cnt}, 32'h0);
    check_reg("abort_r1_cleared", 5'd1, 32'h0);

    // Randomized instruction stream over a small register window to force dependencies.
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      logic [31:0] ins;
      op = op_pool[$urandom_range(0, 7)];
      if (op == 6'b000000)
        ins = mk_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 31)), fn_pool[$urandom_range(0, 5)]);
      else
        ins = mk_i(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      run_instr(ins, n != 0);
    end

    for (int r = 0; r < 8; r++) check_reg("final_rf", 5'(r), model_rf[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential instruction issue/writeback controller that drives the existing single-cycle `ALU` as its only consumer. It accepts 32-bit MIPS-format instruction words over a valid/ready handshake and decodes them onto the ALU ports `OPCODE`, `RS_VAL`, `RT_VAL`, `SHAMT`, `FUNC` and `RAW_VAL`. It reads operands from an internal 32x32 register file, captures `RESULT`/`SIG_B` and writes the result back. It sits between instruction fetch and the ALU in the phase-1 datapath.

## Interface
- `DATA_W`, 32, datapath and register width; only 32 is supported.
- `NREG_W`, 5, register address width; 2**NREG_W registers.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `INSTR`  in  32  instruction word; sampled on an accepted handshake.
- `INSTR_VALID`  in  1  instruction offered.
- `INSTR_READY`  out  1  unit can accept an instruction.
- `OPCODE`  out  6  to the ALU; INSTR[31:26] of the held instruction.
- `RS_VAL`  out  32  to the ALU; regfile[INSTR[25:21]].
- `RT_VAL`  out  32  to the ALU; regfile[INSTR[20:16]].
- `SHAMT`  out  5  to the ALU; INSTR[10:6].
- `FUNC`  out  6  to the ALU; INSTR[5:0].
- `RAW_VAL`  out  16  to the ALU; INSTR[15:0], unextended. The ALU extends it.
- `RESULT`  in  32  from the ALU; combinational result.
- `SIG_B`  in  1  from the ALU; branch condition.
- `DONE`  out  1  one-cycle pulse when an instruction retires.
- `BR_TAKEN`  out  1  `SIG_B` captured for the last retired branch; held until the next retire.
- `WB_EN`, `WB_ADDR[4:0]`, `WB_DATA[31:0]`  out  writeback observation, valid while `DONE` is high.
- `DBG_ADDR`  in  5  debug read address.
- `DBG_DATA`  out  32  combinational regfile[`DBG_ADDR`].

## Operation
- **IDLE**
  - `INSTR_READY`=1.
  - On `INSTR_VALID`&`INSTR_READY`, latch `INSTR` and go to DECODE.
- **DECODE**
  - Register the operand fields and the regfile reads into the ALU-facing output registers.
  - Go to EXEC.
- **EXEC**
  - ALU inputs are stable.
  - Capture `RESULT` into the result register and `SIG_B` into the branch flag.
  - Go to WB.
- **WB**
  - Perform the regfile write when applicable.
  - Pulse `DONE`, drive `WB_*`, update `BR_TAKEN` (branches only).
  - Go to IDLE.
- **Destination rules**
  - OPCODE=000000 (R-type): write to rd = INSTR[15:11].
  - OPCODE in {001000 ADDI, 001010 SLTI, 001100 ANDI, 001101 ORI}: write to rt.
  - OPCODE in {000100 BEQ, 000101 BNE}: no write; `BR_TAKEN`<=`SIG_B`.
  - Any other OPCODE: no write, `DONE` still pulses, `WB_EN`=0.
- **Register 0**
  - Always reads 0.
  - Writes to address 0 are suppressed: `WB_EN`=0, `WB_ADDR`=0.
- **Read-after-write**
  - The next instruction's DECODE occurs after the WB edge.
  - It therefore always sees the prior result; no bypass is needed.
- **Ignored input**
  - `INSTR_VALID` is ignored outside IDLE; `INSTR_READY`=0 there.

## Timing
- **Handshake**: accepted at rising edge N.
  - ALU inputs are valid from N+1 until the next accept.
  - `RESULT` is captured at N+2.
  - `DONE`/`WB_*` are high during cycle N+2..N+3.
  - The regfile write commits at edge N+3.
  - `INSTR_READY`=1 from N+3.
- **Throughput**: one instruction per 4 cycles; a back-to-back accept is possible at N+4 (next accept edge).
- **Reset**
  - All outputs 0, except `DBG_DATA`, which reflects the cleared regfile (0).
  - State=IDLE.
  - All registers cleared to 0.
  - `INSTR_READY` is 1 from the first cycle after `RST` deasserts.
- **Reset mid-operation**: `RST` high in any state aborts the instruction.
  - No regfile write.
  - No `DONE`.
  - `BR_TAKEN` is cleared.
- **`DBG_DATA` during write**: reading the address being written in WB returns the old value until edge N+3.

## Configuration
- `ALU_ISSUE_RETIRE_CNT_EN`
  - **Defined**:
    - Adds output `RETIRED_CNT[15:0]`.
    - It increments on every `DONE` and wraps 0xFFFF->0x0000.
    - It is cleared by `RST`.
  - **Undefined**:
    - The port still exists, tied to 0.
    - No counter logic is synthesized.

## Test plan
- **ADDI r1,r0,13** (0x2001000D):
  - ALU sees `OPCODE`=001000, `RS_VAL`=0, `RAW_VAL`=13.
  - `DONE` is high in the 3rd cycle after accept; `WB_ADDR`=1, `WB_DATA`=13.
  - `DBG_DATA`(1)=13.
- **ADDI r2,r1,19 issued immediately after**:
  - `RS_VAL`=13.
  - r2=32, no hazard.
  - Throughput is exactly 4 cycles per instruction.
- **R-type ADD r3,r1,r2** (FUNC=100000):
  - `RS_VAL`=13, `RT_VAL`=32.
  - r3=45, `WB_ADDR`=3.
- **ADDI r0,r0,9**:
  - `DONE`=1, `WB_EN`=0.
  - `DBG_DATA`(0)=0.
- **BEQ r1,r1,x**:
  - `SIG_B`=1 -> `BR_TAKEN`=1, `WB_EN`=0.
  - No register changes.
  - A following BNE r1,r1 gives `BR_TAKEN`=0.
- **RST asserted in EXEC of ADDI r4,r0,7**:
  - No `DONE`; r4 stays 0.
  - `INSTR_READY`=1 after release.
  - With `ALU_ISSUE_RETIRE_CNT_EN` defined, `RETIRED_CNT`=0.
